// File: rtl/debounce_scheduler_if.sv
// Raw button inputs and debounced results exchanged between the board side and
// the shared-timer debouncer.
interface debounce_scheduler_if #(
    parameter int N = 4
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]  rawIn;
    logic [N-1:0]  level;
    logic [N-1:0]  pressed;
    logic          busy;
    logic [PW-1:0] chan;

    modport master (output rawIn, input level, pressed, busy, chan);
    modport slave  (input rawIn, output level, pressed, busy, chan);
endinterface

// File: rtl/debounce_scheduler.sv
// One debounce timer shared round-robin across N raw inputs; a changed channel
// holds the timer until its new value is stable for maxCount clocks or bounces.
module debounce_scheduler #(
    parameter int          N        = 4,
    parameter logic [25:0] maxCount = 26'd5000
) (
    input  logic                 clock,
    input  logic                 reset,
    debounce_scheduler_if.slave  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {SCAN, QUALIFY} state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [25:0]   delay_q, delay_d;
    logic          cand_q, cand_d;
    logic [N-1:0]  level_q, level_d;
    logic [N-1:0]  pressed_q, pressed_d;
    logic          busy_q, busy_d;
    logic [PW-1:0] ptr_inc;
    logic          sample;

    // Explicit wrap so non-power-of-two N never visits an unused slot.
    assign ptr_inc = (ptr_q == PW'(N - 1)) ? '0 : ptr_q + PW'(1);
    assign sample  = bus.rawIn[ptr_q];

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        delay_d   = delay_q;
        cand_d    = cand_q;
        level_d   = level_q;
        pressed_d = '0;
        busy_d    = busy_q;
        case (state_q)
            SCAN: begin
                if (sample != level_q[ptr_q]) begin
                    cand_d  = sample;
                    delay_d = maxCount;
                    busy_d  = 1'b1;
                    state_d = QUALIFY;
                end else begin
                    ptr_d = ptr_inc;
                end
            end
            QUALIFY: begin
                // A mismatch wins even in the final delay==0 cycle.
                if (sample != cand_q) begin
                    busy_d  = 1'b0;
                    ptr_d   = ptr_inc;
                    state_d = SCAN;
                end else if (delay_q != 26'd0) begin
                    delay_d = delay_q - 26'd1;
                end else begin
                    level_d[ptr_q]   = cand_q;
                    pressed_d[ptr_q] = cand_q;
                    busy_d           = 1'b0;
                    ptr_d            = ptr_inc;
                    state_d          = SCAN;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= SCAN;
            ptr_q     <= '0;
            delay_q   <= '0;
            cand_q    <= 1'b0;
            level_q   <= '0;
            pressed_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            delay_q   <= delay_d;
            cand_q    <= cand_d;
            level_q   <= level_d;
            pressed_q <= pressed_d;
            busy_q    <= busy_d;
        end
    end

    assign bus.level   = level_q;
    assign bus.pressed = pressed_q;
    assign bus.busy    = busy_q;
    assign bus.chan    = ptr_q;
endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (N=4, maxCount=4); press pulses are
// checked against a scoreboard of expected channel/cycle pairs.
module tb_debounce_scheduler;
    localparam int N = 4;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    logic clock;
    logic reset;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb[$];

    debounce_scheduler_if #(.N(N)) bus ();

    debounce_scheduler #(.N(N), .maxCount(26'd4)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Advance until the pointer sits on channel c in SCAN; bounded.
    task automatic wait_chan(input int c);
        int n = 0;
        while (!(int'(bus.chan) == c && bus.busy == 1'b0) && n < 100) begin
            tick();
            n++;
        end
        check("wait_chan", 32'(bus.chan), 32'(c));
    endtask

    // Pulse monitor: every pressed pulse must match the head of the scoreboard.
    always @(posedge clock) begin
        #1;
        if (bus.pressed !== '0) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", 32'(bus.pressed), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_vec", 32'(bus.pressed), 32'd1 << e.ch);
                check("pulse_cyc", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        int t;
        int r;
        reset     = 1'b0;
        bus.rawIn = '0;
        tick();
        tick();
        check("rst_level", 32'(bus.level), 32'd0);
        check("rst_pressed", 32'(bus.pressed), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_chan", 32'(bus.chan), 32'd0);

        // Idle scan: pointer walks 1,2,3,0.
        reset = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("idle_chan", 32'(bus.chan), 32'(i % N));
            check("idle_busy", 32'(bus.busy), 32'd0);
        end

        // Clean press on channel 2.
        wait_chan(2);
        bus.rawIn[2] = 1'b1;
        t = cyc;
        sb.push_back('{ch: 2, cyc: t + 6});
        tick();
        check("press_busy", 32'(bus.busy), 32'd1);
        check("press_hold_chan", 32'(bus.chan), 32'd2);
        for (int i = 0; i < 4; i++) tick();
        check("press_level_pre", 32'(bus.level), 32'd0);
        tick();
        check("press_level", 32'(bus.level), 32'b0100);
        check("press_pulse", 32'(bus.pressed), 32'b0100);
        check("press_busy_fall", 32'(bus.busy), 32'd0);
        tick();
        check("press_pulse_drop", 32'(bus.pressed), 32'd0);

        // Bounce on channel 1 during the second QUALIFY cycle.
        wait_chan(1);
        bus.rawIn[1] = 1'b1;
        tick();
        check("bounce_busy", 32'(bus.busy), 32'd1);
        tick();
        bus.rawIn[1] = 1'b0;
        tick();
        check("bounce_busy_fall", 32'(bus.busy), 32'd0);
        check("bounce_chan", 32'(bus.chan), 32'd2);
        check("bounce_level", 32'(bus.level), 32'b0100);
        check("bounce_pressed", 32'(bus.pressed), 32'd0);

        // Contention: 3 and 0 rise together while pointer is on 3.
        wait_chan(3);
        bus.rawIn[3] = 1'b1;
        bus.rawIn[0] = 1'b1;
        t = cyc;
        sb.push_back('{ch: 3, cyc: t + 6});
        sb.push_back('{ch: 0, cyc: t + 12});
        for (int i = 0; i < 6; i++) tick();
        check("cont_level_3", 32'(bus.level), 32'b1100);
        for (int i = 0; i < 6; i++) tick();
        check("cont_level_0", 32'(bus.level), 32'b1101);

        // Release of channel 0: level falls, no pulse.
        wait_chan(0);
        bus.rawIn[0] = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("rel_level_pre", 32'(bus.level), 32'b1101);
        tick();
        check("rel_level", 32'(bus.level), 32'b1100);
        check("rel_pressed", 32'(bus.pressed), 32'd0);
        check("rel_busy", 32'(bus.busy), 32'd0);

        // Reset during QUALIFY of channel 1 at delay==2.
        wait_chan(1);
        bus.rawIn[1] = 1'b1;
        tick();
        tick();
        tick();
        check("mid_busy", 32'(bus.busy), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_level", 32'(bus.level), 32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        check("mid_rst_chan", 32'(bus.chan), 32'd0);
        check("mid_rst_pressed", 32'(bus.pressed), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        r = cyc;
        // Levels cleared, so 1, 2 and 3 all requalify in pointer order.
        sb.push_back('{ch: 1, cyc: r + 7});
        sb.push_back('{ch: 2, cyc: r + 13});
        sb.push_back('{ch: 3, cyc: r + 19});
        for (int i = 0; i < 6; i++) tick();
        check("requal_level_pre", 32'(bus.level), 32'd0);
        for (int i = 0; i < 16; i++) tick();
        check("requal_level", 32'(bus.level), 32'b1110);
        check("requal_busy", 32'(bus.busy), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
